backend_flush_sequencer: RTL and testbench
==========================================

# backend_flush_sequencer

Sequential controller for backend pause and flush distribution. It merges stage pause requests into the two pipeline-register pauses. It turns a commit-stage flush request into a fixed recovery sequence: a one-cycle flush broadcast, a fixed run of rename-map recovery cycles, then a front-end redirect handshake. It sits between the commit stage, the ROB/issue queues and the instruction-buffer/decode/rename pipeline registers.

## Interface
- `RECOVER_CYCLES`, 4: number of rename-recovery cycles; must be ≥1.
- `ADDR_W`, 32: redirect PC width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_req`  in  1  flush request from commit; sampled every cycle.
- `flush_pc`  in  ADDR_W  redirect target; valid with `flush_req`.
- `pause_req`  in  6  pause requests, one bit per source: bit0 decode/rename regs, bit1 ROB, bit2 IQ ALU0, bit3 IQ ALU1, bit4 IQ LSU, bit5 IQ MDU.
- `ib_dec_pause`  out  1  pause for the instruction-buffer/decode registers.
- `dec_ren_pause`  out  1  pause for the decode/rename registers.
- `flush`  out  1  registered flush broadcast to the ROB, all IQs and the ib/dec registers.
- `rename_recover`  out  1  strobe, high once per recovery cycle.
- `redirect_valid`  out  1  front-end redirect request.
- `redirect_pc`  out  ADDR_W  latched `flush_pc`.
- `redirect_ready`  in  1  front end accepts the redirect.
- `busy`  out  1  high in any state other than IDLE.
- `perf_flush_cnt`  out  32  number of completed flush sequences.
- `perf_stall_cnt`  out  32  number of cycles with `ib_dec_pause` high.

## Operation
- FSM states:
  - IDLE → FLUSH when `flush_req` is high.
  - FLUSH → RECOVER after one cycle.
  - RECOVER → REDIRECT after `RECOVER_CYCLES` cycles.
  - REDIRECT → IDLE on the cycle where `redirect_valid && redirect_ready`.
- `flush_req` high in any state, FLUSH included, forces the next state to FLUSH. The same edge reloads `redirect_pc` from `flush_pc` and clears the recovery counter. The newest request always wins.
- `flush` = (state == FLUSH). `rename_recover` = (state == RECOVER). `redirect_valid` = (state == REDIRECT). `busy` = (state != IDLE).
- Recovery counter:
  - Width is `$clog2(RECOVER_CYCLES+1)`.
  - Loads 0 on entry to RECOVER and increments each RECOVER cycle.
  - The exit compare is counter == `RECOVER_CYCLES-1`.
  - No wrap is possible.
- Pause outputs:
  - In IDLE, `dec_ren_pause` = OR of `pause_req[5:1]`.
  - In IDLE, `ib_dec_pause` = OR of `pause_req[5:0]`. Both are combinational from `pause_req`.
  - In every non-IDLE state, both pauses are forced to 1 regardless of `pause_req`.
- `redirect_pc` holds its value while `redirect_valid` is high. It is unchanged in IDLE.
- Reset mid-sequence:
  - State returns to IDLE.
  - `flush`, `rename_recover`, `redirect_valid` and `busy` go to 0, and `redirect_pc` goes to 0.
  - No redirect is issued for the aborted flush.
- Reset values: state IDLE; all 1-bit outputs 0, except the pauses, which follow `pause_req`. `redirect_pc` 0; perf counters 0.

## Timing
- `flush_req` sampled high at edge t:
  - `flush` is high during cycle t+1 only.
  - `rename_recover` is high during t+2 through t+1+`RECOVER_CYCLES`.
  - `redirect_valid` rises at t+2+`RECOVER_CYCLES`.
- `redirect_valid` is held until the handshake. IDLE and `busy`=0 follow on the next cycle, and the pauses then release.
- Minimum flush-to-idle time is `RECOVER_CYCLES`+3 cycles, reached with `redirect_ready` tied high.
- `flush_req` and `redirect_ready` high together in REDIRECT: the flush wins, the redirect is not consumed, and the FSM re-enters FLUSH.

## Configuration
- `FLUSH_SEQ_PERF_EN` defined:
  - `perf_flush_cnt` increments on each REDIRECT handshake.
  - `perf_stall_cnt` increments on each cycle with `ib_dec_pause` high.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- `FLUSH_SEQ_PERF_EN` undefined: both ports are tied to 0 and no counter flops are generated.

## Structure
- Shared package `backend_ctrl_pkg` holds:
  - the state enum (IDLE, FLUSH, RECOVER, REDIRECT);
  - the pause bit-index constants (`PAUSE_DEC_REN`=0 … `PAUSE_MDU`=5);
  - `PAUSE_SRC_NUM`=6.
- Sub-module `sat_counter32` (enable and reset in, saturating 32-bit count out) is instantiated twice under `FLUSH_SEQ_PERF_EN`.

## Test plan
- Idle pause merge:
  - `pause_req`=6'b000001 → `ib_dec_pause`=1, `dec_ren_pause`=0.
  - `pause_req`=6'b100000 → both 1.
  - 0 → both 0; `busy`=0.
- Basic flush, `RECOVER_CYCLES`=4, `redirect_ready`=1, `flush_req` pulse at t with `flush_pc`=32'h8000_0100:
  - `flush` high at t+1 only.
  - `rename_recover` high for t+2..t+5.
  - `redirect_valid` high at t+6 with `redirect_pc`=32'h8000_0100.
  - `busy`=0 at t+7.
- Backpressure: `redirect_ready`=0 for 5 cycles → `redirect_valid` and both pauses stay high with a stable PC, and IDLE follows the cycle after `redirect_ready` goes to 1.
- Nested flush: second `flush_req` with PC 32'h8000_0200 during the 2nd RECOVER cycle → `flush` is re-asserted, the full 4 recovery cycles restart, and the redirect carries 32'h8000_0200.
- Reset mid-operation: assert `rst_n`=0 asynchronously during RECOVER → outputs reach their reset values immediately, no redirect follows, and the perf counters read 0.
- With `FLUSH_SEQ_PERF_EN`: two complete flushes → `perf_flush_cnt`=2 and `perf_stall_cnt` equals the total number of `ib_dec_pause` cycles. Without the macro, both read 0.

Source files
------------

// File: rtl/backend_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// backend_ctrl_pkg
//
// Shared definitions for the backend control slice. This package holds:
//   - flush_state_e : the flush sequencer FSM states
//                     (IDLE, FLUSH, RECOVER, REDIRECT).
//   - PAUSE_*       : bit positions inside the pause_req vector.
//   - PAUSE_SRC_NUM : the number of pause request sources.
// ---------------------------------------------------------------------------
package backend_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    RECOVER  = 2'd2,
    REDIRECT = 2'd3
  } flush_state_e;

  localparam int PAUSE_SRC_NUM = 6;

  localparam int PAUSE_DEC_REN  = 0;
  localparam int PAUSE_ROB      = 1;
  localparam int PAUSE_IQ_ALU0  = 2;
  localparam int PAUSE_IQ_ALU1  = 3;
  localparam int PAUSE_IQ_LSU   = 4;
  localparam int PAUSE_MDU      = 5;

endpackage

// File: rtl/sat_counter32.sv
// ---------------------------------------------------------------------------
// sat_counter32
//
// A 32-bit event counter that saturates at 32'hFFFF_FFFF. It does not wrap.
//
// Ports:
//   clk   in  1   clock
//   rst_n in  1   asynchronous, active-low reset; clears the count
//   en    in  1   count enable; adds one on each rising edge while high
//   cnt   out 32  current count
// ---------------------------------------------------------------------------
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/backend_flush_sequencer.sv
// ---------------------------------------------------------------------------
// backend_flush_sequencer
//
// This module merges stage pause requests into the ib/dec and dec/ren
// pipeline-register pauses. It also turns a commit flush request into a
// fixed sequence:
//   1. a one-cycle flush broadcast;
//   2. RECOVER_CYCLES rename-recovery strobes;
//   3. a front-end redirect handshake.
// A new flush_req in any state restarts the sequence, and the newest PC wins.
//
// Parameters:
//   RECOVER_CYCLES  number of rename-recovery cycles (>= 1)
//   ADDR_W          redirect PC width
//
// Ports:
//   clk             in   1        clock
//   rst_n           in   1        asynchronous, active-low reset
//   flush_req       in   1        flush request from commit
//   flush_pc        in   ADDR_W   redirect target, qualified by flush_req
//   pause_req       in   6        per-source pause requests (see package)
//   ib_dec_pause    out  1        ib/dec register pause
//   dec_ren_pause   out  1        dec/ren register pause
//   flush           out  1        flush broadcast (state FLUSH)
//   rename_recover  out  1        rename recovery strobe (state RECOVER)
//   redirect_valid  out  1        front-end redirect request (state REDIRECT)
//   redirect_pc     out  ADDR_W   latched flush_pc
//   redirect_ready  in   1        front end accepts the redirect
//   busy            out  1        sequencer is not idle
//   perf_flush_cnt  out  32       completed flush sequences
//   perf_stall_cnt  out  32       cycles with ib_dec_pause high
//
// Build option:
//   FLUSH_SEQ_PERF_EN  enables the saturating perf counters. When it is not
//                      defined, both perf outputs are tied to zero.
// ---------------------------------------------------------------------------
module backend_flush_sequencer
  import backend_ctrl_pkg::*;
#(
  parameter int RECOVER_CYCLES = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_req,
  input  logic [ADDR_W-1:0]        flush_pc,
  input  logic [PAUSE_SRC_NUM-1:0] pause_req,
  output logic                     ib_dec_pause,
  output logic                     dec_ren_pause,
  output logic                     flush,
  output logic                     rename_recover,
  output logic                     redirect_valid,
  output logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     redirect_ready,
  output logic                     busy,
  output logic [31:0]              perf_flush_cnt,
  output logic [31:0]              perf_stall_cnt
);

  localparam int               CNT_W    = $clog2(RECOVER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RECOVER_CYCLES - 1);

  flush_state_e     state, state_nxt;
  logic [CNT_W-1:0] recov_cnt, recov_cnt_nxt;

  // State register and recovery counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      recov_cnt <= '0;
    end else begin
      state     <= state_nxt;
      recov_cnt <= recov_cnt_nxt;
    end
  end

  // Next-state logic. The flush_req override comes last, so a new flush
  // in any state, even in the middle of a handshake, restarts the sequence.
  always_comb begin
    state_nxt     = state;
    recov_cnt_nxt = recov_cnt;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      FLUSH: begin
        state_nxt     = RECOVER;
        recov_cnt_nxt = '0;
      end
      RECOVER: begin
        if (recov_cnt == CNT_LAST) begin
          state_nxt = REDIRECT;
        end else begin
          recov_cnt_nxt = recov_cnt + 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (flush_req) begin
      state_nxt     = FLUSH;
      recov_cnt_nxt = '0;
    end
  end

  // Redirect target. It reloads only on a flush request, so the value stays
  // stable through RECOVER and REDIRECT and also while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc <= '0;
    end else if (flush_req) begin
      redirect_pc <= flush_pc;
    end
  end

  // State-decoded outputs
  assign flush          = (state == FLUSH);
  assign rename_recover = (state == RECOVER);
  assign redirect_valid = (state == REDIRECT);
  assign busy           = (state != IDLE);

  // Pause merge. The dec/ren pause ignores its own register's request
  // (bit PAUSE_DEC_REN); only downstream consumers can stall it.
  assign dec_ren_pause = busy | (|pause_req[PAUSE_MDU:PAUSE_ROB]);
  assign ib_dec_pause  = busy | (|pause_req);

`ifdef FLUSH_SEQ_PERF_EN
  // A handshake that coincides with a new flush is not consumed.
  logic redirect_done;
  assign redirect_done = redirect_valid & redirect_ready & ~flush_req;

  sat_counter32 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (redirect_done),
    .cnt   (perf_flush_cnt)
  );

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ib_dec_pause),
    .cnt   (perf_stall_cnt)
  );
`else
  assign perf_flush_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_backend_flush_sequencer.sv
// ---------------------------------------------------------------------------
// tb_backend_flush_sequencer
//
// This bench drives the sequencer with directed steps. The expected values
// are worked out by hand with RECOVER_CYCLES=4. The perf expectations
// depend on whether FLUSH_SEQ_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_backend_flush_sequencer;
  import backend_ctrl_pkg::*;

  localparam int RC     = 4;
  localparam int ADDR_W = 32;

`ifdef FLUSH_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic                     flush_req;
  logic [ADDR_W-1:0]        flush_pc;
  logic [PAUSE_SRC_NUM-1:0] pause_req;
  logic                     ib_dec_pause;
  logic                     dec_ren_pause;
  logic                     flush;
  logic                     rename_recover;
  logic                     redirect_valid;
  logic [ADDR_W-1:0]        redirect_pc;
  logic                     redirect_ready;
  logic                     busy;
  logic [31:0]              perf_flush_cnt;
  logic [31:0]              perf_stall_cnt;

  int tests  = 0;
  int errors = 0;

  backend_flush_sequencer #(
    .RECOVER_CYCLES (RC),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_req      (flush_req),
    .flush_pc       (flush_pc),
    .pause_req      (pause_req),
    .ib_dec_pause   (ib_dec_pause),
    .dec_ren_pause  (dec_ren_pause),
    .flush          (flush),
    .rename_recover (rename_recover),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .busy           (busy),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the single-bit outputs as {flush, rename_recover, redirect_valid, busy}.
  task automatic check_st(input string tag, input logic [3:0] exp);
    check(tag, {60'd0, flush, rename_recover, redirect_valid, busy}, {60'd0, exp});
  endtask

  initial begin
    rst_n          = 1'b0;
    flush_req      = 1'b0;
    flush_pc       = '0;
    pause_req      = '0;
    redirect_ready = 1'b0;

    // Reset state
    #12;
    check_st("reset_st", 4'b0000);
    check("reset_pc", 64'(redirect_pc), 64'd0);
    check("reset_pause", {62'd0, ib_dec_pause, dec_ren_pause}, 64'd0);
    check("reset_perf", {perf_flush_cnt, perf_stall_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Idle pause merge, all inside one cycle so no stall cycles are counted
    pause_req = 6'b000001; #1;
    check("pm_dec", {62'd0, ib_dec_pause, dec_ren_pause}, 64'b10);
    pause_req = 6'b100000; #1;
    check("pm_mdu", {62'd0, ib_dec_pause, dec_ren_pause}, 64'b11);
    pause_req = 6'b000000; #1;
    check("pm_none", {62'd0, ib_dec_pause, dec_ren_pause, busy}, 64'b000);
    tick();

    // Basic flush with redirect_ready tied high
    redirect_ready = 1'b1;
    flush_req = 1'b1; flush_pc = 32'h8000_0100;
    tick();                       // cycle t+1
    flush_req = 1'b0; flush_pc = 32'hDEAD_BEEF;
    check_st("bf_flush", 4'b1001);
    check("bf_pause", {62'd0, ib_dec_pause, dec_ren_pause}, 64'b11);
    for (int i = 0; i < RC; i++) begin
      tick();                     // cycles t+2..t+5
      check_st("bf_recover", 4'b0101);
    end
    tick();                       // cycle t+6
    check_st("bf_redirect", 4'b0011);
    check("bf_pc", 64'(redirect_pc), 64'h8000_0100);
    tick();                       // cycle t+7
    check_st("bf_idle", 4'b0000);
    check("bf_pause_rel", {62'd0, ib_dec_pause, dec_ren_pause}, 64'b00);
    check("bf_perf_flush", 64'(perf_flush_cnt), PERF ? 64'd1 : 64'd0);
    check("bf_perf_stall", 64'(perf_stall_cnt), PERF ? 64'd6 : 64'd0);

    // Backpressure: redirect_ready low for five REDIRECT cycles
    redirect_ready = 1'b0;
    flush_req = 1'b1; flush_pc = 32'h8000_0180;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < RC + 1; i++) tick();   // reach t+6
    for (int i = 0; i < 5; i++) begin
      check_st("bp_hold", 4'b0011);
      check("bp_pause", {62'd0, ib_dec_pause, dec_ren_pause}, 64'b11);
      check("bp_pc", 64'(redirect_pc), 64'h8000_0180);
      tick();
    end
    check_st("bp_still", 4'b0011);            // t+11, ready goes high now
    redirect_ready = 1'b1;
    tick();
    check_st("bp_idle", 4'b0000);
    check("bp_perf_flush", 64'(perf_flush_cnt), PERF ? 64'd2 : 64'd0);
    check("bp_perf_stall", 64'(perf_stall_cnt), PERF ? 64'd17 : 64'd0);

    // Nested flush during the second RECOVER cycle
    flush_req = 1'b1; flush_pc = 32'h8000_0100;
    tick();                       // t+1 FLUSH
    flush_req = 1'b0;
    tick();                       // t+2 RECOVER #1
    tick();                       // t+3 RECOVER #2
    check_st("nf_rec2", 4'b0101);
    flush_req = 1'b1; flush_pc = 32'h8000_0200;
    tick();
    flush_req = 1'b0;
    check_st("nf_reflush", 4'b1001);
    check("nf_pc_reload", 64'(redirect_pc), 64'h8000_0200);
    for (int i = 0; i < RC; i++) begin
      tick();
      check_st("nf_recover", 4'b0101);
    end
    tick();
    check_st("nf_redirect", 4'b0011);
    check("nf_pc", 64'(redirect_pc), 64'h8000_0200);
    tick();
    check_st("nf_idle", 4'b0000);
    check("nf_perf_flush", 64'(perf_flush_cnt), PERF ? 64'd3 : 64'd0);
    check("nf_perf_stall", 64'(perf_stall_cnt), PERF ? 64'd26 : 64'd0);

    // A flush in REDIRECT together with redirect_ready: the flush wins
    flush_req = 1'b1; flush_pc = 32'h8000_0280;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < RC + 1; i++) tick();   // t+6 REDIRECT
    check_st("fr_redirect", 4'b0011);
    flush_req = 1'b1; flush_pc = 32'h8000_0300;
    tick();
    flush_req = 1'b0;
    check_st("fr_reflush", 4'b1001);
    check("fr_perf_flush", 64'(perf_flush_cnt), PERF ? 64'd3 : 64'd0);
    for (int i = 0; i < RC + 1; i++) tick();
    check_st("fr_redirect2", 4'b0011);
    check("fr_pc", 64'(redirect_pc), 64'h8000_0300);
    tick();
    check_st("fr_idle", 4'b0000);
    check("fr_perf_flush2", 64'(perf_flush_cnt), PERF ? 64'd4 : 64'd0);
    check("fr_perf_stall", 64'(perf_stall_cnt), PERF ? 64'd38 : 64'd0);

    // Reset asserted asynchronously during RECOVER
    flush_req = 1'b1; flush_pc = 32'h8000_0400;
    tick();
    flush_req = 1'b0;
    tick();
    tick();                       // RECOVER #2
    check_st("rm_pre", 4'b0101);
    #2 rst_n = 1'b0;
    #1;
    check_st("rm_async", 4'b0000);
    check("rm_pc", 64'(redirect_pc), 64'd0);
    check("rm_pause", {62'd0, ib_dec_pause, dec_ren_pause}, 64'b00);
    check("rm_perf", {perf_flush_cnt, perf_stall_cnt}, 64'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < RC + 4; i++) begin
      tick();
      check_st("rm_no_redirect", 4'b0000);
    end

    // Two complete flushes plus three idle stall cycles, counted from reset
    redirect_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      flush_req = 1'b1; flush_pc = 32'h8000_0500 + 32'(k);
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < RC + 2; i++) tick();
      check_st("pc_idle", 4'b0000);
    end
    pause_req = 6'b000100;
    #1;
    check("pc_iq_pause", {62'd0, ib_dec_pause, dec_ren_pause}, 64'b11);
    for (int i = 0; i < 3; i++) tick();
    pause_req = 6'b000000;
    tick();
    check("pc_perf_flush", 64'(perf_flush_cnt), PERF ? 64'd2 : 64'd0);
    check("pc_perf_stall", 64'(perf_stall_cnt), PERF ? 64'd15 : 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
